// File: rtl/vga_sync_recover.sv
// Receive-side VGA timing recovery: rebuilds x/y/video_on/new_frame from
// hsync/vsync falls, measures line and frame length, and tracks lock.
module vga_sync_recover #(
  parameter int H_DISPLAY   = 640,
  parameter int H_R_BORDER  = 16,
  parameter int H_RETRACE   = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_DISPLAY   = 480,
  parameter int V_B_BORDER  = 10,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1600
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       new_frame,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines
);
  // h_meas is widened so it reaches TIMEOUT before it saturates
  localparam int HMW = ($clog2(TIMEOUT + 2) > 10) ? $clog2(TIMEOUT + 2) : 10;
  localparam int GW  = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;

  localparam logic [HMW-1:0] HM_MAX  = '1;
  localparam logic [HMW-1:0] HM_LINE = HMW'(H_TOTAL - 1);
  localparam logic [HMW-1:0] HM_TMO  = HMW'(TIMEOUT);
  localparam logic [9:0]     X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]     Y_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]     X_SYNC  = 10'(H_DISPLAY + H_R_BORDER);
  localparam logic [9:0]     Y_SYNC  = 10'(V_DISPLAY + V_B_BORDER);
  localparam logic [9:0]     X_VIS   = 10'(H_DISPLAY);
  localparam logic [9:0]     Y_VIS   = 10'(V_DISPLAY);
  localparam logic [10:0]    F_LINES = 11'(V_TOTAL);
  localparam logic [GW-1:0]  G_LAST  = GW'(LOCK_FRAMES - 1);

  if (H_DISPLAY + H_R_BORDER + H_RETRACE > H_TOTAL || TIMEOUT <= H_TOTAL) begin : g_bad_cfg
    $error("vga_sync_recover: inconsistent timing parameters");
  end

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t         state;
  logic           hs_q, hs_p, vs_q, vs_p;
  logic [HMW-1:0] h_meas;
  logic [9:0]     v_meas;
  logic [GW-1:0]  good_cnt;
  logic           first_h, first_v;

  logic           h_fall, v_fall, checking, h_bad, v_bad, tmo;
  logic           h_err_n, v_err_n, bad, lock_now, locked_n, x_wrap;
  logic [HMW:0]   h_len;
  logic [10:0]    f_cnt;
  logic [9:0]     x_n, y_n;

  always_comb begin
    h_fall   = hs_p & ~hs_q;
    v_fall   = vs_p & ~vs_q;
    h_len    = {1'b0, h_meas} + {{HMW{1'b0}}, 1'b1};
    // an hsync fall coincident with the vsync fall closes the outgoing frame
    f_cnt    = {1'b0, v_meas} + {10'd0, h_fall};
    checking = (state != SEARCH);
    h_bad    = h_fall && !first_h && (h_meas != HM_LINE);
    tmo      = !h_fall && (h_meas == HM_TMO);
    v_bad    = v_fall && !first_v && (f_cnt != F_LINES);
    h_err_n  = checking && (h_bad || tmo);
    v_err_n  = checking && v_bad;
    bad      = h_err_n || v_err_n;
    lock_now = (state == VERIFY) && v_fall && !bad && (good_cnt == G_LAST);
    locked_n = ((state == LOCKED) && !bad) || lock_now;
    x_wrap   = !h_fall && (x == X_LAST);
    // the fall is seen one pipeline stage late, so loading X_SYNC here lands
    // two cycles behind the source, which is the intended output alignment
    x_n      = h_fall ? X_SYNC : (x_wrap ? 10'd0 : x + 10'd1);
    y_n      = y;
    if (v_fall)      y_n = Y_SYNC;
    else if (x_wrap) y_n = (y == Y_LAST) ? 10'd0 : y + 10'd1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hs_q        <= 1'b0;
      hs_p        <= 1'b0;
      vs_q        <= 1'b0;
      vs_p        <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      good_cnt    <= '0;
      first_h     <= 1'b1;
      first_v     <= 1'b1;
      state       <= SEARCH;
      x           <= '0;
      y           <= '0;
      video_on    <= 1'b0;
      new_frame   <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      hs_q <= hsync_in;
      hs_p <= hs_q;
      vs_q <= vsync_in;
      vs_p <= vs_q;

      h_meas <= h_fall ? '0 : ((h_meas == HM_MAX) ? HM_MAX : h_meas + HMW'(1));
      v_meas <= v_fall ? 10'd0 : ((h_fall && v_meas != 10'h3FF) ? v_meas + 10'd1 : v_meas);

      if (h_fall) begin
        first_h  <= 1'b0;
        line_len <= (|h_len[HMW:10]) ? 10'h3FF : h_len[9:0];
      end
      if (v_fall) begin
        first_v     <= 1'b0;
        frame_lines <= f_cnt[10] ? 10'h3FF : f_cnt[9:0];
      end

      h_err     <= h_err_n;
      v_err     <= v_err_n;
      x         <= x_n;
      y         <= y_n;
      locked    <= locked_n;
      video_on  <= locked_n && (x_n < X_VIS) && (y_n < Y_VIS);
      new_frame <= locked_n && (x_n == X_LAST) && (y_n == Y_LAST);

      if (bad) begin
        state   <= SEARCH;
        first_h <= 1'b1;
        first_v <= 1'b1;
      end else begin
        unique case (state)
          SEARCH: if (v_fall) begin
            state    <= VERIFY;
            good_cnt <= '0;
          end
          VERIFY: begin
            if (lock_now)    state    <= LOCKED;
            else if (v_fall) good_cnt <= good_cnt + GW'(1);
          end
          LOCKED: ;
          default: state <= SEARCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_recover.sv
// Bench: a scaled-down sync generator drives the recoverer; a queue of
// generator pixels checks the 2-cycle-delayed coordinates while locked.
module tb_vga_sync_recover;
  localparam int HD = 16, HRB = 4, HRT = 8, HT = 32;
  localparam int VD = 12, VBB = 2, VRT = 2, VT = 20;
  localparam int LF = 2, TMO = 64;
  localparam int FR = HT * VT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       nf;
  } pix_t;

  logic       CLK = 1'b0;
  logic       reset, gen_rst;
  logic       hsync_in, vsync_in;
  logic [9:0] x, y, line_len, frame_lines;
  logic       video_on, new_frame, locked, h_err, v_err;

  vga_sync_recover #(
    .H_DISPLAY(HD), .H_R_BORDER(HRB), .H_RETRACE(HRT), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_B_BORDER(VBB), .V_TOTAL(VT),
    .LOCK_FRAMES(LF), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .video_on(video_on), .new_frame(new_frame), .locked(locked),
    .h_err(h_err), .v_err(v_err), .line_len(line_len), .frame_lines(frame_lines)
  );

  always #20 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // reference generator with stall, line-skip, forced-hsync and vsync-shape knobs
  int   gx, gy;
  logic gen_stall = 1'b0, gen_skip = 1'b0, gen_vmode = 1'b0, hs_force = 1'b0;
  logic g_hs, g_vs;

  always @(posedge CLK or posedge gen_rst) begin
    if (gen_rst) begin
      gx <= 0;
      gy <= 0;
    end else if (!gen_stall) begin
      if (gx == HT - 1) begin
        gx <= 0;
        gy <= (gen_skip && gy == 3) ? 5 : ((gy == VT - 1) ? 0 : gy + 1);
      end else begin
        gx <= gx + 1;
      end
    end
  end

  always_comb begin
    g_hs = !(gx >= HD + HRB && gx < HD + HRB + HRT);
    if (gen_vmode)
      g_vs = !((gy == VD + VBB && gx >= HD + HRB) || (gy > VD + VBB && gy < VD + VBB + VRT) ||
               (gy == VD + VBB + VRT && gx < HD + HRB));
    else
      g_vs = !(gy >= VD + VBB && gy < VD + VBB + VRT);
  end

  assign hsync_in = g_hs | hs_force;
  assign vsync_in = g_vs;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pix_t gen_pix();
    pix_t p;
    p.x  = gx[9:0];
    p.y  = gy[9:0];
    p.vo = (gx < HD) && (gy < VD);
    p.nf = (gx == HT - 1) && (gy == VT - 1);
    return p;
  endfunction

  pix_t dut_pix;
  assign dut_pix = '{x: x, y: y, vo: video_on, nf: new_frame};

  logic [44:0] outs;
  assign outs = {x, y, video_on, new_frame, locked, h_err, v_err, line_len, frame_lines};

  // scoreboard: every cycle the generator's pixel is queued; the DUT must
  // present it two cycles later
  pix_t sbq[$];
  bit   sb_en = 1'b0;
  always @(negedge CLK) begin
    pix_t e;
    sbq.push_back(gen_pix());
    if (sbq.size() > 2) begin
      e = sbq.pop_front();
      if (sb_en) chk("align", 64'(dut_pix), 64'(e));
    end
  end

  int n_herr = 0, n_verr = 0, n_vo_bad = 0;
  always @(negedge CLK) begin
    if (h_err) n_herr <= n_herr + 1;
    if (v_err) n_verr <= n_verr + 1;
    if (!locked && (video_on || new_frame)) n_vo_bad <= n_vo_bad + 1;
  end

  function automatic logic probe(input int s);
    case (s)
      0:       return h_err;
      1:       return v_err;
      2:       return !vsync_in;
      default: return locked;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int s, input int budget);
    int n = 0;
    while (!probe(s) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 64'(probe(s)), 64'd1);
  endtask

  task automatic wait_gen(input int yy, input int xx);
    int n = 0;
    while (!(gy == yy && gx == xx) && n < 2 * FR) begin
      @(negedge CLK);
      n++;
    end
    chk("gen_pos", {gy, gx}, {yy, xx});
  endtask

  task automatic run_sb(input int cycles);
    sb_en = 1'b1;
    repeat (cycles) @(negedge CLK);
    sb_en = 1'b0;
  endtask

  initial begin
    int t0, h0, v0;
    reset   = 1'b1;
    gen_rst = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_outs", 64'(outs), 64'd0);
    reset   = 1'b0;
    gen_rst = 1'b0;

    // 1: clean lock, latency, alignment, measurements
    wait_for("first_vs", 2, 2 * FR);
    t0 = cyc;
    wait_for("lock1", 3, 4 * FR);
    chk("lock_latency", 64'((cyc - t0 >= 2 * FR - 3) && (cyc - t0 <= 2 * FR + 3)), 64'd1);
    run_sb(3 * FR);
    chk("line_len", 64'(line_len), 64'(HT));
    chk("frame_lines", 64'(frame_lines), 64'(VT));
    chk("no_herr", 64'(n_herr), 64'd0);
    chk("no_verr", 64'(n_verr), 64'd0);

    // 2: one stretched line
    h0 = n_herr; v0 = n_verr;
    wait_gen(5, 10);
    gen_stall = 1'b1;
    @(negedge CLK);
    gen_stall = 1'b0;
    wait_for("herr_long", 0, 4 * HT);
    chk("long_len", 64'(line_len), 64'(HT + 1));
    chk("long_unlock", 64'(locked), 64'd0);
    wait_for("relock2", 3, 5 * FR);
    chk("long_herr_once", 64'(n_herr - h0), 64'd1);
    chk("long_no_verr", 64'(n_verr - v0), 64'd0);
    run_sb(FR);

    // 3: one dropped line
    h0 = n_herr; v0 = n_verr;
    wait_gen(2, 0);
    gen_skip = 1'b1;
    wait_gen(6, 0);
    gen_skip = 1'b0;
    wait_for("verr_short", 1, 2 * FR);
    chk("short_lines", 64'(frame_lines), 64'(VT - 1));
    chk("short_unlock", 64'(locked), 64'd0);
    wait_for("relock3", 3, 5 * FR);
    chk("short_verr_once", 64'(n_verr - v0), 64'd1);
    chk("short_no_herr", 64'(n_herr - h0), 64'd0);
    chk("vo_forced_off", 64'(n_vo_bad), 64'd0);

    // 4: hsync stuck high past the timeout
    h0 = n_herr; v0 = n_verr;
    wait_gen(2, 0);
    hs_force = 1'b1;
    repeat (80) @(negedge CLK);
    hs_force = 1'b0;
    repeat (40) @(negedge CLK);
    chk("tmo_unlock", 64'(locked), 64'd0);
    chk("tmo_herr_once", 64'(n_herr - h0), 64'd1);
    wait_for("relock4", 3, 5 * FR);
    chk("tmo_no_repeat", 64'(n_herr - h0), 64'd1);
    chk("tmo_no_verr", 64'(n_verr - v0), 64'd0);

    // 5: reset pulse mid-frame while locked
    wait_gen(8, 5);
    reset = 1'b1;
    #1;
    chk("async_reset", 64'(outs), 64'd0);
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    h0 = n_herr; v0 = n_verr;
    wait_for("relock5", 3, 5 * FR);
    chk("rst_no_herr", 64'(n_herr - h0), 64'd0);
    chk("rst_no_verr", 64'(n_verr - v0), 64'd0);
    run_sb(FR);

    // 6: vsync and hsync fall together at each frame boundary
    reset     = 1'b1;
    gen_rst   = 1'b1;
    gen_vmode = 1'b1;
    repeat (3) @(negedge CLK);
    reset   = 1'b0;
    gen_rst = 1'b0;
    h0 = n_herr; v0 = n_verr;
    wait_for("relock6", 3, 5 * FR);
    run_sb(2 * FR);
    chk("coinc_no_verr", 64'(n_verr - v0), 64'd0);
    chk("coinc_no_herr", 64'(n_herr - h0), 64'd0);
    chk("coinc_lines", 64'(frame_lines), 64'(VT));
    chk("coinc_locked", 64'(locked), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: cycles=%0d limit=60000", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
